// File: rtl/cordic_vector.sv
// cordic_vector: iterative CORDIC vectoring, returns |(x,y)| and atan2(y,x).
// Define CORDIC_VECTOR_GAIN_COMP_EN to add the SCALE gain-compensation step.
module cordic_vector #(
    parameter int DW   = 10,
    parameter int AW   = DW,
    parameter int ITER = DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] xin,
    input  logic signed [DW-1:0] yin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW+1:0] mag,
    output logic signed [AW-1:0] ang
);

    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int XW = DW + 2;

    // atan(2^-k)/pi scaled by 2^AW, truncated; series is exact enough for k>=1
    function automatic logic [AW:0] theta_f(int k);
        real t;
        real p;
        real s;
        real r;
        if (k == 0) begin
            r = 0.25;
        end else begin
            t = 1.0;
            for (int j = 0; j < k; j++) t = t / 2.0;
            p = t;
            s = 0.0;
            for (int n = 0; n < 40; n++) begin
                if (n % 2 == 0) s = s + p / (2.0 * n + 1.0);
                else            s = s - p / (2.0 * n + 1.0);
                p = p * t * t;
            end
            r = s / 3.14159265358979;
        end
        for (int j = 0; j < AW; j++) r = r * 2.0;
        return (AW+1)'($rtoi(r));
    endfunction

    typedef enum logic [1:0] {IDLE, ROT, SCALE, DONE} state_t;

    state_t               state, state_nx;
    logic signed [XW-1:0] x, y, x_nx, y_nx;
    logic signed [XW-1:0] xs, ys, xe, ye;
    logic signed [AW:0]   a, a_nx;
    logic [IW-1:0]        i, i_nx;
    logic                 zero, zero_nx;
    logic signed [XW-1:0] mag_nx;
    logic signed [AW-1:0] ang_nx;
    logic [AW:0]          theta [ITER];

    // elaboration-time arctangent table
    for (genvar g = 0; g < ITER; g++) begin : g_theta
        localparam logic [AW:0] TH = theta_f(g);
        assign theta[g] = TH;
    end

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
    localparam logic [DW:0] LAMBDA =
        (DW+1)'($rtoi(0.6072529350 * (2.0 ** DW) + 0.5));

    logic signed [XW+DW+1:0] prod;

    // x times 1/K, both non-negative in practice
    assign prod = x * $signed({1'b0, LAMBDA});
`endif

    assign xe        = {{2{xin[DW-1]}}, xin};
    assign ye        = {{2{yin[DW-1]}}, yin};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // next state, micro-rotation datapath and result capture
    always_comb begin
        state_nx = state;
        x_nx     = x;
        y_nx     = y;
        a_nx     = a;
        i_nx     = i;
        zero_nx  = zero;
        mag_nx   = mag;
        ang_nx   = ang;
        xs       = x >>> i;
        ys       = y >>> i;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    zero_nx = (xin == '0) && (yin == '0);
                    i_nx    = '0;
                    if (xin[DW-1]) begin
                        x_nx = -xe;
                        y_nx = -ye;
                        a_nx = {1'b1, {AW{1'b0}}};
                    end else begin
                        x_nx = xe;
                        y_nx = ye;
                        a_nx = '0;
                    end
                    state_nx = ROT;
                end
            end
            ROT: begin
                if (!y[XW-1]) begin
                    x_nx = x + ys;
                    y_nx = y - xs;
                    a_nx = a + $signed(theta[i]);
                end else begin
                    x_nx = x - ys;
                    y_nx = y + xs;
                    a_nx = a - $signed(theta[i]);
                end
                if (i == IW'(ITER - 1)) begin
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
                    state_nx = SCALE;
`else
                    state_nx = DONE;
                    mag_nx   = zero ? '0 : x_nx;
                    ang_nx   = zero ? '0 : AW'(a_nx >>> 1);
`endif
                end else begin
                    i_nx = i + 1'b1;
                end
            end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
            SCALE: begin
                mag_nx   = zero ? '0 : XW'(prod >>> DW);
                ang_nx   = zero ? '0 : AW'(a >>> 1);
                state_nx = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            a     <= '0;
            i     <= '0;
            zero  <= 1'b0;
            mag   <= '0;
            ang   <= '0;
        end else begin
            state <= state_nx;
            x     <= x_nx;
            y     <= y_nx;
            a     <= a_nx;
            i     <= i_nx;
            zero  <= zero_nx;
            mag   <= mag_nx;
            ang   <= ang_nx;
        end
    end

endmodule
